// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch front end.
package fetch_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  // One pending redirect: v = entry occupied, flush = misprediction flush
  // (squashes IF/ID when applied), pc = redirect target.
  typedef struct packed {
    logic            v;
    logic            flush;
    logic [PC_W-1:0] pc;
  } redirect_t;

endpackage

// File: rtl/fetch_redirect_hold.sv
// One-entry hold register that keeps BTB redirects arriving while fetch is
// stalled, so they can be applied on the first unstalled edge.
module fetch_redirect_hold
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            take,
  input  logic [PC_W-1:0] target,
  output redirect_t       pend
);

  redirect_t pend_next;

  // Capture priority while stalled: a flush always wins and overwrites; a
  // prediction replaces an older prediction but never a held flush.
  // Any unstalled cycle consumes the entry, so it clears.
  always_comb begin
    pend_next = pend;
    if (!stall) begin
      pend_next = '0;
    end else if (flush) begin
      pend_next.v     = 1'b1;
      pend_next.flush = 1'b1;
      pend_next.pc    = target;
    end else if (take && !(pend.v && pend.flush)) begin
      pend_next.v     = 1'b1;
      pend_next.flush = 1'b0;
      pend_next.pc    = target;
    end
  end

  // Hold register state; reset discards any held redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= pend_next;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// IF program counter, IF/ID pipeline register and saturating flush counter.
// Flow control: STALL is the only back-pressure. When STALL=0 the PC advances
// and IF/ID accepts the fetched word on the edge; when STALL=1 both hold and
// redirects are parked in the hold register instead of being lost.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             FLUSH_IN,
  input  logic             take_Branch_IN,
  input  logic [31:0]      take_Alt_PC_IN,
  input  logic [31:0]      Instr_IN,
  output logic [31:0]      Instr_PC_OUT_IF,
  output logic [31:0]      Instr_PC_OUT_ID,
  output logic [31:0]      Instr_OUT_ID,
  output logic             valid_OUT_ID,
  output logic             pred_Taken_OUT_ID,
  output logic             redirect_pending_OUT,
  output logic [CNT_W-1:0] flush_count_OUT
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  redirect_t   pend;
  logic [31:0] next_pc;
  logic        squash;
  logic        apply_flush;

  fetch_redirect_hold u_hold (
    .clk    (CLK),
    .rst    (RESET),
    .stall  (STALL),
    .flush  (FLUSH_IN),
    .take   (take_Branch_IN),
    .target (take_Alt_PC_IN),
    .pend   (pend)
  );

  assign redirect_pending_OUT = pend.v;

  // A held flush squashes the ID slot exactly like a live one; a live flush
  // coinciding with a held flush is still a single applied flush.
  assign squash      = FLUSH_IN || (pend.v && pend.flush);
  assign apply_flush = !STALL && squash;

  // Next-PC priority: live flush, held redirect, live prediction, sequential.
  always_comb begin
    next_pc = Instr_PC_OUT_IF + PC_INC;
    if (FLUSH_IN) begin
      next_pc = take_Alt_PC_IN;
    end else if (pend.v) begin
      next_pc = pend.pc;
    end else if (take_Branch_IN) begin
      next_pc = take_Alt_PC_IN;
    end
  end

  // PC and IF/ID register advance together on every unstalled edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Instr_PC_OUT_IF   <= RESET_PC;
      Instr_PC_OUT_ID   <= '0;
      Instr_OUT_ID      <= '0;
      valid_OUT_ID      <= 1'b0;
      pred_Taken_OUT_ID <= 1'b0;
    end else if (!STALL) begin
      Instr_PC_OUT_IF   <= next_pc;
      Instr_PC_OUT_ID   <= Instr_PC_OUT_IF;
      Instr_OUT_ID      <= Instr_IN;
      valid_OUT_ID      <= !squash;
      pred_Taken_OUT_ID <= take_Branch_IN && !FLUSH_IN && !pend.v;
    end
  end

  // Count applied flushes, sticking at all-ones.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      flush_count_OUT <= '0;
    end else if (apply_flush && (flush_count_OUT != CNT_MAX)) begin
      flush_count_OUT <= flush_count_OUT + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a default instance and a CNT_W=2 instance
// share all inputs; expected outputs are queued per step and checked after
// each edge.
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam int EW = 32 + 32 + 32 + 3 + 16 + 2;

  logic        CLK;
  logic        RESET;
  logic        STALL;
  logic        FLUSH_IN;
  logic        take_Branch_IN;
  logic [31:0] take_Alt_PC_IN;
  logic [31:0] Instr_IN;

  logic [31:0] pc_if, pc_id, instr_id;
  logic        valid_id, pred_id, pend;
  logic [15:0] cnt;

  logic [31:0] pc_if2, pc_id2, instr_id2;
  logic        valid_id2, pred_id2, pend2;
  logic [1:0]  cnt2;

  logic [EW-1:0] exp_q[$];
  int checks;
  int errors;
  logic [31:0] cur_pc;
  logic        id_live;

  fetch_pc_unit #(.RESET_PC(RST_PC), .CNT_W(16)) dut (
    .CLK                  (CLK),
    .RESET                (RESET),
    .STALL                (STALL),
    .FLUSH_IN             (FLUSH_IN),
    .take_Branch_IN       (take_Branch_IN),
    .take_Alt_PC_IN       (take_Alt_PC_IN),
    .Instr_IN             (Instr_IN),
    .Instr_PC_OUT_IF      (pc_if),
    .Instr_PC_OUT_ID      (pc_id),
    .Instr_OUT_ID         (instr_id),
    .valid_OUT_ID         (valid_id),
    .pred_Taken_OUT_ID    (pred_id),
    .redirect_pending_OUT (pend),
    .flush_count_OUT      (cnt)
  );

  fetch_pc_unit #(.RESET_PC(RST_PC), .CNT_W(2)) dut_sat (
    .CLK                  (CLK),
    .RESET                (RESET),
    .STALL                (STALL),
    .FLUSH_IN             (FLUSH_IN),
    .take_Branch_IN       (take_Branch_IN),
    .take_Alt_PC_IN       (take_Alt_PC_IN),
    .Instr_IN             (Instr_IN),
    .Instr_PC_OUT_IF      (pc_if2),
    .Instr_PC_OUT_ID      (pc_id2),
    .Instr_OUT_ID         (instr_id2),
    .valid_OUT_ID         (valid_id2),
    .pred_Taken_OUT_ID    (pred_id2),
    .redirect_pending_OUT (pend2),
    .flush_count_OUT      (cnt2)
  );

  // Clock and initial reset.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h1234_5678;
  endfunction

  function automatic logic [1:0] sat2(input logic [15:0] c);
    return (c > 16'd3) ? 2'd3 : c[1:0];
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Pop one expectation and compare every output of both instances.
  task automatic compare(input string tag);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s queue: observed empty expected entry", tag);
      return;
    end
    e = exp_q.pop_front();
    chk32({tag, " pc_if"},    pc_if,            e[116:85]);
    chk32({tag, " pc_id"},    pc_id,            e[84:53]);
    chk32({tag, " instr_id"}, instr_id,         e[52:21]);
    chk32({tag, " valid"},    {31'b0, valid_id}, {31'b0, e[20]});
    chk32({tag, " pred"},     {31'b0, pred_id},  {31'b0, e[19]});
    chk32({tag, " pending"},  {31'b0, pend},     {31'b0, e[18]});
    chk32({tag, " count"},    {16'b0, cnt},      {16'b0, e[17:2]});
    chk32({tag, " sat_pc_if"},   pc_if2,    e[116:85]);
    chk32({tag, " sat_pc_id"},   pc_id2,    e[84:53]);
    chk32({tag, " sat_instr"},   instr_id2, e[52:21]);
    chk32({tag, " sat_flags"},   {29'b0, valid_id2, pred_id2, pend2}, {29'b0, e[20:18]});
    chk32({tag, " sat_count"},   {30'b0, cnt2}, {30'b0, e[1:0]});
  endtask

  task automatic push_exp(input logic [31:0] e_pc, input logic [31:0] e_id_pc,
                          input logic [31:0] e_instr, input logic e_valid,
                          input logic e_pred, input logic e_pend,
                          input logic [15:0] e_cnt);
    exp_q.push_back({e_pc, e_id_pc, e_instr, e_valid, e_pred, e_pend, e_cnt, sat2(e_cnt)});
  endtask

  // Drive one cycle of stimulus, queue what must appear after the edge, check.
  task automatic step(input logic st, input logic fl, input logic tk,
                      input logic [31:0] tgt, input logic [31:0] e_pc,
                      input logic [31:0] e_id_pc, input logic e_valid,
                      input logic e_pred, input logic e_pend,
                      input logic [15:0] e_cnt, input string tag);
    logic [31:0] e_instr;
    STALL          = st;
    FLUSH_IN       = fl;
    take_Branch_IN = tk;
    take_Alt_PC_IN = tgt;
    Instr_IN       = instr_of(cur_pc);
    if (!st) id_live = 1'b1;
    e_instr = id_live ? instr_of(e_id_pc) : 32'h0;
    push_exp(e_pc, e_id_pc, e_instr, e_valid, e_pred, e_pend, e_cnt);
    @(posedge CLK);
    #1;
    compare(tag);
    cur_pc = e_pc;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    id_live = 1'b0;
    cur_pc = RST_PC;
    RESET = 1'b1;
    STALL = 1'b0;
    FLUSH_IN = 1'b0;
    take_Branch_IN = 1'b0;
    take_Alt_PC_IN = 32'h0;
    Instr_IN = 32'h0;

    repeat (2) @(posedge CLK);
    #1;
    push_exp(RST_PC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
    compare("reset");
    RESET = 1'b0;

    // Sequential fetch out of reset.
    step(0, 0, 0, 32'h0,         32'hBFC0_0004, RST_PC,        1, 0, 0, 16'd0, "seq0");
    step(0, 0, 0, 32'h0,         32'hBFC0_0008, 32'hBFC0_0004, 1, 0, 0, 16'd0, "seq1");
    // Predicted-taken redirect.
    step(0, 0, 1, 32'h0040_0100, 32'h0040_0100, 32'hBFC0_0008, 1, 1, 0, 16'd0, "pred");
    // Live flush squashes the ID slot.
    step(0, 1, 0, 32'h0040_0200, 32'h0040_0200, 32'h0040_0100, 0, 0, 0, 16'd1, "flush");
    step(0, 0, 0, 32'h0,         32'h0040_0204, 32'h0040_0200, 1, 0, 0, 16'd1, "after_flush");
    // Flush then prediction during a stall: flush is kept.
    step(1, 1, 0, 32'h0040_0300, 32'h0040_0204, 32'h0040_0200, 1, 0, 1, 16'd1, "stall_flush");
    step(1, 0, 1, 32'h0040_0400, 32'h0040_0204, 32'h0040_0200, 1, 0, 1, 16'd1, "stall_pred");
    step(1, 0, 0, 32'h0,         32'h0040_0204, 32'h0040_0200, 1, 0, 1, 16'd1, "stall_idle");
    step(0, 0, 0, 32'h0,         32'h0040_0300, 32'h0040_0204, 0, 0, 0, 16'd2, "held_flush");
    step(0, 0, 0, 32'h0,         32'h0040_0304, 32'h0040_0300, 1, 0, 0, 16'd2, "post_held");
    // Newer held prediction replaces older one.
    step(1, 0, 1, 32'h0040_0500, 32'h0040_0304, 32'h0040_0300, 1, 0, 1, 16'd2, "hold_p1");
    step(1, 0, 1, 32'h0040_0600, 32'h0040_0304, 32'h0040_0300, 1, 0, 1, 16'd2, "hold_p2");
    step(0, 0, 0, 32'h0,         32'h0040_0600, 32'h0040_0304, 1, 0, 0, 16'd2, "held_pred");
    // Held prediction outranks a live prediction.
    step(1, 0, 1, 32'h0040_0700, 32'h0040_0600, 32'h0040_0304, 1, 0, 1, 16'd2, "hold_p3");
    step(0, 0, 1, 32'h0040_0800, 32'h0040_0700, 32'h0040_0600, 1, 0, 0, 16'd2, "held_vs_live");
    // PC wrap.
    step(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0040_0700, 1, 1, 0, 16'd2, "to_top");
    step(0, 0, 0, 32'h0,         32'h0000_0000, 32'hFFFF_FFFC, 1, 0, 0, 16'd2, "wrap");
    step(0, 0, 0, 32'h0,         32'h0000_0004, 32'h0000_0000, 1, 0, 0, 16'd2, "post_wrap");
    // More flushes: the 2-bit counter saturates at 3.
    step(0, 1, 0, 32'h0000_1000, 32'h0000_1000, 32'h0000_0004, 0, 0, 0, 16'd3, "sat_f1");
    step(0, 1, 0, 32'h0000_2000, 32'h0000_2000, 32'h0000_1000, 0, 0, 0, 16'd4, "sat_f2");
    step(0, 1, 1, 32'h0000_3000, 32'h0000_3000, 32'h0000_2000, 0, 0, 0, 16'd5, "sat_f3");
    // Held flush plus live flush on release counts once; live target wins.
    step(1, 1, 0, 32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 0, 0, 1, 16'd5, "dbl_hold");
    step(0, 1, 0, 32'h0000_5000, 32'h0000_5000, 32'h0000_3000, 0, 0, 0, 16'd6, "dbl_apply");
    // Reset while a redirect is held: immediate, no clock edge needed.
    step(1, 0, 1, 32'h0000_6000, 32'h0000_5000, 32'h0000_3000, 0, 0, 1, 16'd6, "pre_reset");
    RESET = 1'b1;
    #1;
    push_exp(RST_PC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
    compare("async_reset");
    @(posedge CLK);
    #1;
    STALL = 1'b0;
    take_Branch_IN = 1'b0;
    RESET = 1'b0;
    id_live = 1'b0;
    cur_pc = RST_PC;
    step(0, 0, 0, 32'h0,         32'hBFC0_0004, RST_PC,        1, 0, 0, 16'd0, "reset_release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
